// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU slice: default datapath width, opcode
// encoding, flag bit positions inside the 4-bit {Z,C,N,V} flag vector and the
// control FSM state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Default operand / result width
    localparam int unsigned ALU_WIDTH = 8;

    // Opcodes as seen on the 3-bit op port
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    // Bit positions within flags = {Z,C,N,V}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage : alu_pkg

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier, one partial-product step per step_i cycle.
// The caller owns the iteration count; this block only holds the operands and
// the running 2*WIDTH-bit accumulator.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset, clears all state
//   load_i     capture a_i/b_i and clear the accumulator
//   step_i     perform one shift-add step
//   a_i, b_i   multiplicand / multiplier (sampled on load_i)
//   product_o  accumulator value including the step in progress
// -----------------------------------------------------------------------------
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] product_o
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;

    // product_o is the post-step value so the controller can capture the
    // complete product on the same edge that performs the final step.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign product_o = acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule : alu_mul_iter

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// Accumulator-style ALU with a registered result and {Z,C,N,V} flags.
// Single-cycle ops complete on the accepting edge; MUL iterates WIDTH cycles
// through alu_mul_iter. The result reaches the bus only while OE is high.
//
// Ports:
//   CLK      clock, rising edge
//   RESET    synchronous active-high reset (wins over start)
//   acc_in   operand A
//   b_in     operand B
//   op       opcode (see alu_pkg::alu_op_e)
//   start    request; accepted in IDLE or DONE, ignored while multiplying
//   OE       output enable; ALU_out is zero when low
//   ALU_out  registered result gated by OE
//   busy     high while a MUL is iterating
//   done     one-cycle pulse when result and flags have been updated
//   flags    registered {Z,C,N,V}
// -----------------------------------------------------------------------------
module alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             OE,
    output logic [WIDTH-1:0] ALU_out,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    alu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    alu_op_e            op_e;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    logic               mul_load;
    logic               mul_step;
    logic [2*WIDTH-1:0] mul_product;

    assign op_e = alu_op_e'(op);

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated straight from the inputs so the
    // accepting edge both samples the operands and commits the result.
    // ------------------------------------------------------------------
    always_comb begin
        add_ext = {1'b0, acc_in} + {1'b0, b_in};
        sub_ext = {1'b0, acc_in} - {1'b0, b_in};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (acc_in[MSB] == b_in[MSB]) && (alu_res[MSB] != acc_in[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                // Carry means "no borrow", i.e. A >= B unsigned
                alu_c   = ~sub_ext[WIDTH];
                alu_v   = (acc_in[MSB] != b_in[MSB]) && (alu_res[MSB] != acc_in[MSB]);
            end
            OP_AND: alu_res = acc_in & b_in;
            OP_OR:  alu_res = acc_in | b_in;
            OP_XOR: alu_res = acc_in ^ b_in;
            OP_SHL: begin
                alu_res = {acc_in[WIDTH-2:0], 1'b0};
                alu_c   = acc_in[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, acc_in[WIDTH-1:1]};
                alu_c   = acc_in[0];
            end
            default: begin
                // MUL is handled by the iterative path
                alu_res = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next state, iteration count, result/flag updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        mul_load = 1'b0;
        mul_step = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (op_e == OP_MUL) begin
                        mul_load = 1'b1;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = ST_MUL;
                    end else begin
                        result_d        = alu_res;
                        flags_d         = '0;
                        flags_d[FLAG_Z] = (alu_res == '0);
                        flags_d[FLAG_C] = alu_c;
                        flags_d[FLAG_N] = alu_res[MSB];
                        flags_d[FLAG_V] = alu_v;
                        state_d         = ST_DONE;
                    end
                end
            end

            ST_MUL: begin
                // start is deliberately ignored here
                mul_step = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d        = mul_product[WIDTH-1:0];
                    flags_d         = '0;
                    flags_d[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
                    flags_d[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_N] = mul_product[MSB];
                    state_d         = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .a_i       (acc_in),
        .b_i       (b_in),
        .product_o (mul_product)
    );

    assign ALU_out = OE ? result_q : '0;
    assign busy    = (state_q == ST_MUL);
    assign done    = (state_q == ST_DONE);
    assign flags   = flags_q;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
// Scoreboard bench for alu_unit: the driver pushes the expected result, flags
// and completion cycle for every accepted request; a negedge monitor pops and
// compares on each done pulse and checks that busy, flags and ALU_out hold
// their values in between.
// -----------------------------------------------------------------------------
module tb_alu_unit;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [W-1:0] acc_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2:0]   op = '0;
    logic         start = 1'b0;
    logic         OE = 1'b0;
    logic [W-1:0] ALU_out;
    logic         busy;
    logic         done;
    logic [3:0]   flags;

    always #5 CLK = ~CLK;

    alu_unit #(
        .WIDTH (W)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .acc_in  (acc_in),
        .b_in    (b_in),
        .op      (op),
        .start   (start),
        .OE      (OE),
        .ALU_out (ALU_out),
        .busy    (busy),
        .done    (done),
        .flags   (flags)
    );

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         mul_cyc = 0;
    bit         mul_active = 0;
    bit         mon_en = 0;
    logic [7:0] hold_res = '0;
    logic [3:0] hold_flg = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on the opcode rules
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t m;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r = 0;
        int sr;
        bit c = 0;
        bit v = 0;
        case (o)
            3'd0: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            3'd1: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua * 2; c = (ua >= 128); end
            3'd6: begin r = ua / 2; c = (ua % 2) == 1; end
            default: begin r = ua * ub; c = (r > 255); end
        endcase
        r = r & 255;
        m.res = r[7:0];
        m.flg = {(r == 0), c, (r >= 128), v};
        m.cyc = 0;
        return m;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge CLK) begin : monitor
        exp_t e;
        bit   e_busy;
        if (mon_en) begin
            e_busy = mul_active && ((cyc - mul_cyc) < 8);
            check("busy", int'(busy), int'(e_busy));
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("flags", int'(flags), int'(e.flg));
                    check("alu_out", int'(ALU_out), OE ? int'(e.res) : 0);
                    hold_res = e.res;
                    hold_flg = e.flg;
                end
            end else begin
                check("hold_flags", int'(flags), int'(hold_flg));
                check("hold_out", int'(ALU_out), OE ? int'(hold_res) : 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (called away from the rising edge)
    // ------------------------------------------------------------------
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic oe);
        exp_t e;
        acc_in = a;
        b_in   = b;
        op     = o;
        OE     = oe;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        e = model(o, a, b);
        e.cyc = (o == 3'd7) ? cyc + 8 : cyc;
        exp_q.push_back(e);
        if (o == 3'd7) begin
            mul_active = 1;
            mul_cyc    = cyc;
        end
        start  = 1'b0;
        acc_in = 8'($urandom);
        b_in   = 8'($urandom);
        op     = 3'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done=0 expected 1 within 20 cycles", name);
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        logic [2:0] ro;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       roe;

        RESET = 1'b1;
        OE    = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_alu_out", int'(ALU_out), 0);
        check("rst_flags", int'(flags), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        #1;
        // start asserted together with RESET must be ignored
        acc_in = 8'h12; b_in = 8'h34; op = 3'd0; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        RESET = 1'b0;
        mon_en = 1;

        issue(3'd0, 8'h7F, 8'h01, 1'b1);
        wait_done("add_7f");
        check("add_7f_res", int'(ALU_out), 'h80);
        check("add_7f_flags", int'(flags), 'b0011);

        idle(2);
        issue(3'd1, 8'h05, 8'h05, 1'b1);
        wait_done("sub_eq");
        check("sub_eq_res", int'(ALU_out), 'h00);
        check("sub_eq_flags", int'(flags), 'b1100);

        // back-to-back from DONE
        issue(3'd1, 8'h00, 8'h01, 1'b1);
        wait_done("sub_borrow");
        check("sub_borrow_res", int'(ALU_out), 'hFF);
        check("sub_borrow_flags", int'(flags), 'b0010);

        idle(1);
        issue(3'd7, 8'h0F, 8'h11, 1'b1);
        wait_done("mul_0f11");
        check("mul_0f11_res", int'(ALU_out), 'hFF);
        check("mul_0f11_flags", int'(flags), 'b0010);

        issue(3'd7, 8'h10, 8'h10, 1'b1);
        wait_done("mul_1010");
        check("mul_1010_res", int'(ALU_out), 'h00);
        check("mul_1010_flags", int'(flags), 'b1100);

        // start during MUL must be ignored
        idle(2);
        issue(3'd7, 8'h0F, 8'h11, 1'b1);
        idle(2);
        acc_in = 8'h44; b_in = 8'h33; op = 3'd0; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done("mul_ign");
        check("mul_ign_res", int'(ALU_out), 'hFF);
        idle(4);

        // RESET part-way through a MUL aborts it
        issue(3'd7, 8'hAB, 8'hCD, 1'b1);
        idle(3);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        mul_active = 0;
        hold_res = '0;
        hold_flg = '0;
        @(negedge CLK);
        check("abort_busy", int'(busy), 0);
        check("abort_flags", int'(flags), 0);
        check("abort_out", int'(ALU_out), 0);
        check("abort_done", int'(done), 0);
        idle(12);

        // OE gating is combinational
        issue(3'd0, 8'h02, 8'h03, 1'b0);
        wait_done("oe_add");
        check("oe_low", int'(ALU_out), 0);
        OE = 1'b1;
        #1;
        check("oe_high", int'(ALU_out), 'h05);
        idle(1);

        for (int n = 0; n < 60; n++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            roe = 1'($urandom_range(0, 1));
            issue(ro, ra, rb, roe);
            wait_done("rand");
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(5);
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_unit
